booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
- Multi-cycle radix-2 Booth multiply unit, shared between two requesters (port 0: ALU mult path, port 1: address/MAC path).
- Round-robin arbitration grants one operand pair at a time.
- Performs one Booth add/sub-and-shift step per clock.
- Returns the signed 2*WIDTH-bit product with a one-cycle done pulse tagged with the requester id.
- Sits beside the ALU; replaces the flat combinational multiplier where timing requires it.

Parameters:
- WIDTH, 8, operand width in bits. Signed two's complement; both operands have the same width.
- CNT_W, 4, step counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high until gnt0 is sampled high.
- a0  input  WIDTH  requester 0 multiplicand.
- b0  input  WIDTH  requester 0 multiplier.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 multiplicand.
- b1  input  WIDTH  requester 1 multiplier.
- gnt0  output  1  combinational; operands of port 0 are captured at this edge.
- gnt1  output  1  combinational; operands of port 1 are captured at this edge.
- busy  output  1  high from the cycle after a grant through the DONE cycle.
- done  output  1  one-cycle pulse; product is valid.
- done_id  output  1  requester served by the current or most recent done.
- product  output  2*WIDTH  signed product; holds its value until the next done.

Behaviour:
- Reset: async, active-high. Values while reset is asserted:
  - FSM goes to IDLE; rr_last=1 so port 0 wins the first tie.
  - gnt0=gnt1=busy=done=done_id=0; product=0.
  - AC, QR, BR, qnext and count are cleared.
  - Reset mid-operation aborts the operation; no done is produced and the aborted requester is not retried.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - Only req0: gnt0=1. Only req1: gnt1=1.
  - Both: grant the port != rr_last.
  - At the grant edge, latch BR=a_sel and QR=b_sel, AC=0 (WIDTH+1 bits, sign-extended), qnext=0, count=0, id=sel, rr_last=sel. Go to STEP.
  - No req: stay in IDLE.
  - gnt is never high outside IDLE.
- STEP, one Booth step per cycle:
  - Case {QR[0],qnext}: 01 -> AC=AC+sext(BR); 10 -> AC=AC-sext(BR); 00/11 -> no change.
  - Then arithmetic right shift of {AC,QR,qnext} by one.
  - count increments; after step WIDTH (count==WIDTH-1 at the edge), go to DONE.
- DONE:
  - done=1, done_id=id.
  - product={AC[WIDTH-1:0],QR}, registered at entry to DONE.
  - Next state is IDLE.
  - req lines are not sampled in DONE: a request arriving there waits one cycle.
- Latency: done is high exactly WIDTH+1 cycles after the grant edge, i.e. 9 cycles for WIDTH=8. Throughput is one multiply per WIDTH+2 cycles.
- Arithmetic: the AC guard bit (WIDTH+1) makes every case exact, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2) (16384 for W=8). No special-case override.
- Operand changes after the grant edge have no effect.
- A requester holding req after its grant is treated as a new request at the next IDLE.

Optional Feature:
- Macro: MULT_EARLY_DONE_EN.
- Defined: if the latched multiplicand or multiplier is zero at the grant edge, FSM goes IDLE -> DONE directly, skipping STEP. done fires 1 cycle after the grant with product=0 and the correct done_id.
- Not defined: zero operands take the full WIDTH+1-cycle path.
- Nonzero operands: identical behaviour either way.

Test Plan:
- req0 only, a0=3, b0=5 -> gnt0 in the same cycle; done 9 cycles later; product=16'd15; done_id=0; busy high for the 9 cycles.
- req1 only, a1=-7 (8'hF9), b1=6 -> product=16'hFFD6 (-42); done_id=1.
- req0, a0=8'h80, b0=8'h80 -> product=16'h4000; also a=8'h80, b=8'h7F -> 16'hC080.
- req0 and req1 held continuously from reset:
  - Grants alternate 0,1,0,1.
  - Each done is 9 cycles after its grant; back-to-back grants are 10 cycles apart.
  - Products are tagged correctly.
- Assert reset in the 4th STEP cycle -> all outputs 0 immediately; no done; the next req0 after reset is granted normally with a correct result.
- a0=0, b0=25:
  - Without the macro: done at +9, product=0.
  - With MULT_EARLY_DONE_EN: done at +1, product=0.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Shared radix-2 Booth multiplier with two round-robin arbitrated requesters.
// Optional build macro MULT_EARLY_DONE_EN: zero operands skip the Booth steps.
module booth_mult_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     ac_q, ac_d, ac_sum, br_ext;
    logic [WIDTH-1:0]   qr_q, qr_d, br_q, br_d;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               qn_q, qn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               rr_last_q, rr_last_d;
    logic               done_id_q, done_id_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               grant, sel;

    // Handshake: a requester holds req with stable operands until it sees its
    // gnt high; the rising edge on which gnt is high is the transfer edge.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        if (state_q == IDLE && !reset) begin
            grant = req0 | req1;
            sel   = (req0 && req1) ? ~rr_last_q : req1;
        end
    end

    assign gnt0  = grant & ~sel;
    assign gnt1  = grant & sel;
    assign a_sel = sel ? a1 : a0;
    assign b_sel = sel ? b1 : b0;

    // The guard bit keeps -2^(W-1) * -2^(W-1) exact.
    always_comb begin
        br_ext = {br_q[WIDTH-1], br_q};
        case ({qr_q[0], qn_q})
            2'b01:   ac_sum = ac_q + br_ext;
            2'b10:   ac_sum = ac_q - br_ext;
            default: ac_sum = ac_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        qr_d      = qr_q;
        br_d      = br_q;
        qn_d      = qn_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        done_id_d = done_id_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    br_d      = a_sel;
                    qr_d      = b_sel;
                    ac_d      = '0;
                    qn_d      = 1'b0;
                    cnt_d     = '0;
                    id_d      = sel;
                    rr_last_d = sel;
`ifdef MULT_EARLY_DONE_EN
                    if (a_sel == '0 || b_sel == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                        done_id_d = sel;
                    end else begin
                        state_d = STEP;
                    end
`else
                    state_d = STEP;
`endif
                end
            end
            STEP: begin
                ac_d  = {ac_sum[WIDTH], ac_sum[WIDTH:1]};
                qr_d  = {ac_sum[0], qr_q[WIDTH-1:1]};
                qn_d  = qr_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = {ac_d[WIDTH-1:0], qr_d};
                    done_id_d = id_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ac_q      <= '0;
            qr_q      <= '0;
            br_q      <= '0;
            qn_q      <= 1'b0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            rr_last_q <= 1'b1;
            done_id_q <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            qr_q      <= qr_d;
            br_q      <= br_d;
            qn_q      <= qn_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
            done_id_q <= done_id_d;
            product_q <= product_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign done_id   = done_id_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: latency, products, tags, round robin, reset abort.
module tb_booth_mult_arbiter;

    localparam int W = 8;
`ifdef MULT_EARLY_DONE_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 9;
`endif

    logic           clk;
    logic           reset;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, busy, done, done_id;
    logic [2*W-1:0] product;
    logic [1:0]     dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic           exp_id_q[$];

    booth_mult_arbiter #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'h55; b0 = 8'h55; a1 = 8'h33; b1 = 8'h33;
        repeat (2) @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_done_id", 32'(done_id), 0);
        check("rst_product", 32'(product), 0);
        check("rst_state", 32'(dbg_state), 0);
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", 32'(busy), 0);
    endtask

    // Scoreboard: compare the current done against the oldest expected result.
    task automatic sb_check(input string tag, output logic [2*W-1:0] exp_p);
        logic exp_id;
        exp_p  = '1;
        exp_id = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
        end else begin
            exp_p  = exp_q.pop_front();
            exp_id = exp_id_q.pop_front();
            check({tag, "_product"}, 32'(product), 32'(exp_p));
            check({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
        end
    endtask

    task automatic do_mult(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input int exp_lat, input string tag);
        int lat;
        int busy_cycles;
        logic [2*W-1:0] held;
        @(negedge clk);
        if (p) begin req1 = 1'b1; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; end
        exp_q.push_back(exp);
        exp_id_q.push_back(p);
        #1;
        check({tag, "_gnt"}, 32'(p ? gnt1 : gnt0), 1);
        check({tag, "_gnt_other"}, 32'(p ? gnt0 : gnt1), 0);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cycles++;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        sb_check(tag, held);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_busy_clear"}, 32'(busy), 0);
        check({tag, "_product_hold"}, 32'(product), 32'(held));
    endtask

    initial begin
        int g_cyc[$];
        int d_cyc[$];
        logic g_id[$];
        int n_done;
        logic [2*W-1:0] held;

        apply_reset();

        do_mult(1'b0, 8'd3,  8'd5,  16'd15,   9, "p0_3x5");
        do_mult(1'b1, 8'hF9, 8'd6,  16'hFFD6, 9, "p1_m7x6");
        do_mult(1'b0, 8'h80, 8'h80, 16'h4000, 9, "p0_min_x_min");
        do_mult(1'b0, 8'h80, 8'h7F, 16'hC080, 9, "p0_min_x_max");
        do_mult(1'b1, 8'h7F, 8'h7F, 16'h3F01, 9, "p1_max_x_max");
        do_mult(1'b1, 8'hFF, 8'hFF, 16'h0001, 9, "p1_m1_x_m1");

        // Reset in the 4th STEP cycle aborts the operation.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd7;
        #1;
        check("abort_gnt0", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_step", 32'(dbg_state), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_done_id", 32'(done_id), 0);
        check("abort_product", 32'(product), 0);
        check("abort_state", 32'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 0);
        do_mult(1'b0, 8'd3, 8'd7, 16'd21, 9, "after_abort");

        do_mult(1'b0, 8'd0, 8'd25, 16'd0, ZERO_LAT, "p0_zero_a");
        do_mult(1'b1, 8'd9, 8'd0,  16'd0, ZERO_LAT, "p1_zero_b");

        // Both requesters held continuously from reset.
        apply_reset();
        @(negedge clk);
        req0 = 1'b1; a0 = 8'd2;  b0 = 8'd3;
        req1 = 1'b1; a1 = 8'hFE; b1 = 8'd5;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                exp_q.push_back((g_cyc.size() % 2 == 1) ? 16'hFFF6 : 16'd6);
                exp_id_q.push_back(g_cyc.size() % 2 == 1);
                g_cyc.push_back(cyc);
                g_id.push_back(gnt1);
            end
            if (done === 1'b1) begin
                d_cyc.push_back(cyc);
                sb_check("rr", held);
            end
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        check("rr_grant_count", 32'(g_cyc.size()), 4);
        check("rr_done_count", 32'(d_cyc.size()), 4);
        for (int k = 0; k < 4; k++) begin
            check("rr_grant_id", (k < g_id.size()) ? 32'(g_id[k]) : 32'hFFFF_FFFF, 32'(k % 2));
            check("rr_grant_cycle", (k < g_cyc.size()) ? 32'(g_cyc[k]) : 32'hFFFF_FFFF, 32'(10 * k));
            check("rr_done_cycle", (k < d_cyc.size()) ? 32'(d_cyc[k]) : 32'hFFFF_FFFF, 32'(10 * k + 9));
        end
        repeat (3) @(negedge clk);
        check("rr_idle_after", 32'(busy), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
